// File: rtl/valid_ready_pkg.sv
// valid_ready_pkg: shared types and helpers for the group accumulator.
// Provides the saturating/wrapping adder and the beat-counter width helper.
package valid_ready_pkg;

    // Widest sum the shared adder supports; SUM_W must not exceed this.
    localparam int unsigned ADD_W = 32;

    typedef logic [ADD_W-1:0] add_t;

    typedef struct packed {
        logic clamped;
        add_t sum;
    } add_res_t;

    // Bits needed to hold a beat count of 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Adds two values that each fit in sum_w bits.
    // sat_mode=0 wraps modulo 2^sum_w; sat_mode=1 clamps to all-ones
    // and reports the clamp.
    function automatic add_res_t sat_add(
        input add_t a,
        input add_t b,
        input int   sum_w,
        input logic sat_mode
    );
        logic [ADD_W:0] w_full;
        logic [ADD_W:0] w_lim;
        add_res_t       w_res;
        w_full = {1'b0, a} + {1'b0, b};
        w_lim  = ({{ADD_W{1'b0}}, 1'b1} << sum_w) - 1'b1;
        w_res.clamped = 1'b0;
        w_res.sum     = w_full[ADD_W-1:0];
        if (w_full > w_lim) begin
            if (sat_mode) begin
                w_res.clamped = 1'b1;
                w_res.sum     = w_lim[ADD_W-1:0];
            end else begin
                w_res.sum = w_full[ADD_W-1:0] & w_lim[ADD_W-1:0];
            end
        end
        return w_res;
    endfunction

endpackage

// File: rtl/valid_ready_accum.sv
// valid_ready_accum: sums up to GROUP_N valid/ready beats into one word.
// Ports: clk, rst_n (async low); data_in/valid_a/last_a/ready_a upstream;
// data_out/cnt_out/sat_out/valid_b/ready_b downstream.
module valid_ready_accum
    import valid_ready_pkg::*;
#(
    parameter int   DATA_W   = 8,
    parameter int   GROUP_N  = 4,
    parameter int   SUM_W    = DATA_W + $clog2(GROUP_N),
    parameter bit   SAT_MODE = 1'b0,
    localparam int  CNT_W    = cnt_width(GROUP_N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_a,
    input  logic              last_a,
    output logic              ready_a,
    output logic              valid_b,
    input  logic              ready_b,
    output logic [SUM_W-1:0]  data_out,
    output logic [CNT_W-1:0]  cnt_out,
    output logic              sat_out
);

    // Accumulator stage
    logic [SUM_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;

    // Output stage
    logic             r_valid_b;
    logic [SUM_W-1:0] r_data;
    logic [CNT_W-1:0] r_cnt_out;
    logic             r_sat_out;

    add_res_t         w_add;
    logic [SUM_W-1:0] w_sum;
    logic             w_clamp;
    logic             w_sat_next;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_full_grp;
    logic             w_closing;
    logic             w_out_stall;
    logic             w_ready;
    logic             w_accept;
    logic             w_out_fire;
    logic             w_unused;

    assign w_add      = sat_add(add_t'(r_acc), add_t'(data_in),
                                SUM_W, SAT_MODE);
    assign w_sum      = w_add.sum[SUM_W-1:0];
    assign w_clamp    = w_add.clamped;
    // Upper adder bits are always zero once narrowed to SUM_W.
    assign w_unused   = ^w_add.sum;
    assign w_sat_next = r_sat | w_clamp;
    assign w_cnt_inc  = r_cnt + CNT_W'(1);

    assign w_full_grp  = (r_cnt == CNT_W'(GROUP_N - 1));
    // last_a is looked at even without valid_a; only accepted beats act.
    assign w_closing   = w_full_grp || last_a;
    assign w_out_stall = r_valid_b && !ready_b;
    // Only a closing beat needs the output register, so only it stalls.
    assign w_ready     = !w_out_stall || !w_closing;
    assign w_accept    = valid_a && w_ready;
    assign w_out_fire  = r_valid_b && ready_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sat     <= 1'b0;
            r_valid_b <= 1'b0;
            r_data    <= '0;
            r_cnt_out <= '0;
            r_sat_out <= 1'b0;
        end else begin
            if (w_accept && w_closing) begin
                // Hand the finished group to the output stage; this also
                // covers a same-cycle drain of the previous result.
                r_data    <= w_sum;
                r_cnt_out <= w_cnt_inc;
                r_sat_out <= w_sat_next;
                r_valid_b <= 1'b1;
                r_acc     <= '0;
                r_cnt     <= '0;
                r_sat     <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_acc <= w_sum;
                    r_cnt <= w_cnt_inc;
                    r_sat <= w_sat_next;
                end
                if (w_out_fire) begin
                    r_valid_b <= 1'b0;
                end
            end
        end
    end

    assign ready_a  = w_ready;
    assign valid_b  = r_valid_b;
    assign data_out = r_data;
    assign cnt_out  = r_cnt_out;
    assign sat_out  = r_sat_out;

endmodule

// File: tb/tb_valid_ready_accum.sv
// tb_valid_ready_accum: random and directed checks of the group accumulator.
// Three instances (wrap/10, clamp/9, wrap/9) share one stimulus stream.
module tb_valid_ready_accum;

    localparam int GROUP_N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = '0;
    logic       valid_a = 1'b0;
    logic       last_a = 1'b0;
    logic       ready_b = 1'b0;

    logic       ra0, ra1, ra2;
    logic       vb0, vb1, vb2;
    logic [9:0] do0;
    logic [8:0] do1, do2;
    logic [2:0] co0, co1, co2;
    logic       so0, so1, so2;

    always #5 clk = ~clk;

    valid_ready_accum u_wrap10 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in),
        .valid_a(valid_a), .last_a(last_a), .ready_a(ra0),
        .valid_b(vb0), .ready_b(ready_b), .data_out(do0),
        .cnt_out(co0), .sat_out(so0)
    );

    valid_ready_accum #(.SUM_W(9), .SAT_MODE(1'b1)) u_sat9 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in),
        .valid_a(valid_a), .last_a(last_a), .ready_a(ra1),
        .valid_b(vb1), .ready_b(ready_b), .data_out(do1),
        .cnt_out(co1), .sat_out(so1)
    );

    valid_ready_accum #(.SUM_W(9), .SAT_MODE(1'b0)) u_wrap9 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in),
        .valid_a(valid_a), .last_a(last_a), .ready_a(ra2),
        .valid_b(vb2), .ready_b(ready_b), .data_out(do2),
        .cnt_out(co2), .sat_out(so2)
    );

    int n_pass = 0;
    int n_chk  = 0;

    // Reference model: beats of the open group, plus the held result.
    int grp[$];
    bit m_valid;
    int m_cnt;
    int m_sum[3];
    bit m_sat[3];
    int sum_w[3]  = '{10, 9, 9};
    bit sat_md[3] = '{1'b0, 1'b1, 1'b0};

    function automatic void model_reset();
        grp.delete();
        m_valid = 1'b0;
        m_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            m_sum[k] = 0;
            m_sat[k] = 1'b0;
        end
    endfunction

    // Unsigned beats only grow the sum, so clamping per beat equals
    // clamping the group total once.
    function automatic void model_close();
        int total;
        int lim;
        total = 0;
        foreach (grp[i]) total += grp[i];
        for (int k = 0; k < 3; k++) begin
            lim = (1 << sum_w[k]) - 1;
            if (sat_md[k]) begin
                m_sum[k] = (total > lim) ? lim : total;
                m_sat[k] = (total > lim);
            end else begin
                m_sum[k] = total % (lim + 1);
                m_sat[k] = 1'b0;
            end
        end
        m_cnt = grp.size();
        m_valid = 1'b1;
        grp.delete();
    endfunction

    // One clock of stimulus, scoreboarding the outputs of the previous edge.
    task automatic drive_beat(input bit v, input int d, input bit l,
                              input bit rb);
        logic [9:0] a_sum[3];
        logic [2:0] a_cnt[3];
        logic       a_v[3];
        logic       a_s[3];
        logic       a_r[3];
        bit         closing;
        bit         exp_r;
        bit         fire_out;
        @(negedge clk);
        a_v   = '{vb0, vb1, vb2};
        a_sum = '{do0, {1'b0, do1}, {1'b0, do2}};
        a_cnt = '{co0, co1, co2};
        a_s   = '{so0, so1, so2};
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (a_v[k] !== m_valid)
                $display("FAIL valid_b dut%0d: got %0b expected %0b",
                         k, a_v[k], m_valid);
            else n_pass++;
            if (m_valid) begin
                n_chk++;
                if (a_sum[k] !== 10'(m_sum[k]))
                    $display("FAIL data_out dut%0d: got %0d expected %0d",
                             k, a_sum[k], m_sum[k]);
                else n_pass++;
                n_chk++;
                if (a_cnt[k] !== 3'(m_cnt))
                    $display("FAIL cnt_out dut%0d: got %0d expected %0d",
                             k, a_cnt[k], m_cnt);
                else n_pass++;
                n_chk++;
                if (a_s[k] !== m_sat[k])
                    $display("FAIL sat_out dut%0d: got %0b expected %0b",
                             k, a_s[k], m_sat[k]);
                else n_pass++;
            end
        end
        data_in = d[7:0];
        valid_a = v;
        last_a  = l;
        ready_b = rb;
        #1;
        closing = (grp.size() == GROUP_N - 1) || l;
        exp_r = !(m_valid && !rb) || !closing;
        a_r = '{ra0, ra1, ra2};
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (a_r[k] !== exp_r)
                $display("FAIL ready_a dut%0d: got %0b expected %0b",
                         k, a_r[k], exp_r);
            else n_pass++;
        end
        fire_out = m_valid && rb;
        if (v && exp_r) begin
            grp.push_back(d);
            if (closing) model_close();
            else if (fire_out) m_valid = 1'b0;
        end else if (fire_out) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic hold_reset();
        @(negedge clk);
        valid_a = 1'b0;
        last_a  = 1'b0;
        ready_b = 1'b0;
        rst_n   = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        hold_reset();
        n_chk++;
        if ({vb0, vb1, vb2} !== 3'b000)
            $display("FAIL reset_valid: got %b expected 000", {vb0, vb1, vb2});
        else n_pass++;
        n_chk++;
        if (do0 !== 10'd0 || do1 !== 9'd0 || co0 !== 3'd0 || so1 !== 1'b0)
            $display("FAIL reset_data: got %0d/%0d/%0d/%0b expected 0",
                     do0, do1, co0, so1);
        else n_pass++;
        release_reset();
        #1;
        n_chk++;
        if ({ra0, ra1, ra2} !== 3'b111)
            $display("FAIL reset_ready: got %b expected 111", {ra0, ra1, ra2});
        else n_pass++;
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 4; i++) drive_beat(1, i, 0, 1);
        drive_beat(0, 0, 0, 1);
        n_chk++;
        if (vb0 !== 1'b1 || do0 !== 10'd10 || co0 !== 3'd4 || so0 !== 1'b0)
            $display("FAIL basic_sum: got v%0b %0d c%0d s%0b expected v1 10 c4 s0",
                     vb0, do0, co0, so0);
        else n_pass++;
        drive_beat(0, 0, 0, 1);
        n_chk++;
        if (vb0 !== 1'b0)
            $display("FAIL basic_pulse: got %0b expected 0", vb0);
        else n_pass++;
    endtask

    task automatic test_no_carry();
        for (int i = 0; i < 4; i++) drive_beat(1, 255, 0, 1);
        drive_beat(1, 1, 0, 1);
        n_chk++;
        if (do0 !== 10'd1020 || so0 !== 1'b0)
            $display("FAIL max_sum: got %0d s%0b expected 1020 s0", do0, so0);
        else n_pass++;
        for (int i = 0; i < 3; i++) drive_beat(1, 1, 0, 1);
        drive_beat(0, 0, 0, 1);
        n_chk++;
        if (do0 !== 10'd4 || co0 !== 3'd4)
            $display("FAIL no_carry: got %0d c%0d expected 4 c4", do0, co0);
        else n_pass++;
    endtask

    task automatic test_last();
        drive_beat(1, 5, 0, 1);
        drive_beat(1, 6, 1, 1);
        drive_beat(1, 7, 0, 1);
        n_chk++;
        if (do0 !== 10'd11 || co0 !== 3'd2)
            $display("FAIL early_last: got %0d c%0d expected 11 c2", do0, co0);
        else n_pass++;
        for (int i = 0; i < 3; i++) drive_beat(1, 7, 0, 1);
        drive_beat(0, 0, 0, 1);
        n_chk++;
        if (do0 !== 10'd28 || co0 !== 3'd4)
            $display("FAIL after_last: got %0d c%0d expected 28 c4", do0, co0);
        else n_pass++;
    endtask

    task automatic test_stall();
        for (int i = 1; i <= 3; i++) drive_beat(1, i, 0, 1);
        drive_beat(1, 4, 0, 0);
        drive_beat(1, 10, 0, 0);
        drive_beat(1, 20, 0, 0);
        drive_beat(1, 30, 0, 0);
        drive_beat(1, 40, 0, 0);
        n_chk++;
        if (ra0 !== 1'b0 || do0 !== 10'd10)
            $display("FAIL stall_hold: got r%0b %0d expected r0 10", ra0, do0);
        else n_pass++;
        drive_beat(1, 40, 0, 0);
        drive_beat(1, 40, 0, 1);
        drive_beat(0, 0, 0, 0);
        n_chk++;
        if (vb0 !== 1'b1 || do0 !== 10'd100 || co0 !== 3'd4)
            $display("FAIL stall_release: got v%0b %0d c%0d expected v1 100 c4",
                     vb0, do0, co0);
        else n_pass++;
        drive_beat(0, 0, 0, 1);
        drive_beat(0, 0, 0, 1);
    endtask

    task automatic test_sat();
        for (int i = 0; i < 4; i++) drive_beat(1, 200, 0, 1);
        drive_beat(0, 0, 0, 1);
        n_chk++;
        if (do1 !== 9'd511 || so1 !== 1'b1)
            $display("FAIL sat_clamp: got %0d s%0b expected 511 s1", do1, so1);
        else n_pass++;
        n_chk++;
        if (do2 !== 9'd288 || so2 !== 1'b0)
            $display("FAIL sat_wrap: got %0d s%0b expected 288 s0", do2, so2);
        else n_pass++;
        n_chk++;
        if (do0 !== 10'd800)
            $display("FAIL sat_wide: got %0d expected 800", do0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 4; i++) drive_beat(1, i, 0, 0);
        drive_beat(1, 3, 0, 0);
        drive_beat(1, 3, 0, 0);
        hold_reset();
        n_chk++;
        if (vb0 !== 1'b0 || do0 !== 10'd0 || co0 !== 3'd0 || so0 !== 1'b0)
            $display("FAIL midreset_out: got v%0b %0d c%0d s%0b expected 0",
                     vb0, do0, co0, so0);
        else n_pass++;
        release_reset();
        for (int i = 0; i < 4; i++) drive_beat(1, 1, 0, 1);
        drive_beat(0, 0, 0, 1);
        n_chk++;
        if (do0 !== 10'd4 || co0 !== 3'd4)
            $display("FAIL midreset_fresh: got %0d c%0d expected 4 c4", do0, co0);
        else n_pass++;
    endtask

    task automatic test_random();
        int d;
        for (int i = 0; i < 600; i++) begin
            d = ($urandom_range(0, 1) != 0) ? $urandom_range(180, 255)
                                            : $urandom_range(0, 255);
            drive_beat($urandom_range(0, 3) != 0, d,
                       $urandom_range(0, 4) == 0,
                       $urandom_range(0, 2) != 0);
        end
        drive_beat(0, 0, 0, 1);
        drive_beat(0, 0, 0, 1);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_no_carry();
        test_last();
        test_stall();
        test_sat();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
